lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Receive-side checker for the 64-bit XNOR LFSR test-pattern stream used to exercise the LZW datapath.
- Regenerates the expected sequence locally from the same seed and compares it against each incoming sample.
- Reports per-sample pass/fail, sample and error counts, and a capture of the first mismatch.
- Sits at the output end of the test path and closes the loop on the pattern generator.

Parameters:
DATA_W, 12, sample width compared per beat; uses ref_reg[DATA_W-1:0]; legal range 1..64
CNT_W, 32, width of sample_count, err_count and first_err_idx
ERR_STOP, 0, when 1 the first mismatch moves the FSM to DONE

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  pulse: load seed_in, clear all results, enter CHECK
seed_in  input  64  seed, sampled only when start=1
stop  input  1  pulse: end the check run (CHECK->DONE)
in_valid  input  1  in_data carries a sample this cycle
in_data  input  DATA_W  received sample
busy  output  1  FSM is in CHECK
done  output  1  FSM is in DONE
chk_valid  output  1  one-cycle pulse: a sample was compared last cycle
chk_ok  output  1  result of that compare; meaningful only when chk_valid=1
err_flag  output  1  sticky: at least one mismatch since start
sample_count  output  CNT_W  samples compared, saturating
err_count  output  CNT_W  mismatches, saturating
first_err_idx  output  CNT_W  zero-based index of the first mismatching sample
first_err_exp  output  DATA_W  expected value at the first mismatch
first_err_got  output  DATA_W  received value at the first mismatch

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge): FSM=IDLE, ref_reg=0, every output=0. Reset has priority over all other inputs, including mid-run.
- Reference LFSR:
  - fb = ~(ref_reg[63]^ref_reg[62]^ref_reg[60]^ref_reg[59]).
  - Advance: ref_reg <= {ref_reg[62:0], fb}.
  - Expected sample = ref_reg[DATA_W-1:0].
  - All-ones seed locks up, matching the generator; no special handling.
- FSM states: IDLE, CHECK, DONE.
- start=1, in any state:
  - ref_reg<=seed_in; counters, err_flag and first_err_* cleared; chk_valid<=0; FSM<=CHECK.
  - start has priority over stop and in_valid in the same cycle; that sample is dropped.
- IDLE or DONE: in_valid and stop ignored. Outputs hold their values, except chk_valid, which is 0.
- CHECK with in_valid=1 (and start=0):
  - Compare in_data to the expected sample.
  - ref_reg advances whether or not the sample matches. There is no resynchronisation.
  - sample_count +1, saturating at 2^CNT_W-1.
  - Next cycle: chk_valid=1, chk_ok=(match). This is a 1-cycle registered latency.
  - On mismatch: err_count +1 (saturating) and err_flag<=1.
  - If err_flag was 0 before this sample: first_err_idx<=sample_count (pre-increment value), first_err_exp<=expected, first_err_got<=in_data.
  - If ERR_STOP=1 and mismatch: FSM<=DONE.
- CHECK with in_valid=0: ref_reg holds; chk_valid<=0.
- CHECK with stop=1: FSM<=DONE. A valid sample in the same cycle is still compared and counted, then the block stops.
- Saturation: at the maximum count, sample_count holds while comparisons continue. err_count saturates independently. first_err_* is never overwritten until the next start.
- busy and done are registered decodes of FSM state. Both are 0 in IDLE.

Test Plan:
- Seed 0 sequence: start with seed_in=0, then 13 valid samples 000,001,003,007,00F,01F,03F,07F,0FF,1FF,3FF,7FF,FFF -> chk_ok=1 on every pulse; sample_count=13, err_count=0, err_flag=0, busy=1.
- Single error: seed 0, feed 000,001,002,007 -> chk_ok pattern 1,1,0,1; err_count=1, first_err_idx=2, first_err_exp=003, first_err_got=002.
- Valid gaps and stop: seed 0, send 000, idle 3 cycles, send 001, then stop together with 003 -> all match; sample_count=3; done=1, busy=0; further in_valid ignored.
- ERR_STOP=1: seed 0, feed 000,005,003 -> DONE after the second sample; sample_count=2, err_count=1; the third sample is not counted.
- Saturation (CNT_W=4): seed 0, 20 samples all 0xABC -> sample_count=15, err_count=15 (first sample 000 vs ABC is a mismatch); first_err_idx=0.
- Restart and reset: mid-run, start with seed 0 while in_valid=1 -> counters zero and that sample dropped. Mid-run, assert rst for one cycle -> IDLE with all outputs 0; a sample in IDLE is ignored.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 64-bit XNOR LFSR test stream.
// Regenerates the reference sequence and scores each incoming sample.
module lfsr_seq_checker #(
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned CNT_W    = 32,
   parameter bit          ERR_STOP = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [63:0]       seed_in,
   input  logic              stop,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              busy,
   output logic              done,
   output logic              chk_valid,
   output logic              chk_ok,
   output logic              err_flag,
   output logic [CNT_W-1:0]  sample_count,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_got
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e            state_q, state_d;
   logic [63:0]       ref_q, ref_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              chk_valid_q, chk_valid_d;
   logic              chk_ok_q, chk_ok_d;
   logic              err_flag_q, err_flag_d;
   logic [CNT_W-1:0]  sample_count_q, sample_count_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
   logic [DATA_W-1:0] first_err_exp_q, first_err_exp_d;
   logic [DATA_W-1:0] first_err_got_q, first_err_got_d;

   logic              fb;
   logic [DATA_W-1:0] exp_data;
   logic              match;
   logic              take;

   assign fb       = ~(ref_q[63] ^ ref_q[62] ^ ref_q[60] ^ ref_q[59]);
   assign exp_data = ref_q[DATA_W-1:0];
   assign match    = (in_data == exp_data);
   assign take     = (state_q == ST_CHECK) && in_valid && !start;

   always_comb begin
      state_d         = state_q;
      ref_d           = ref_q;
      chk_valid_d     = 1'b0;
      chk_ok_d        = chk_ok_q;
      err_flag_d      = err_flag_q;
      sample_count_d  = sample_count_q;
      err_count_d     = err_count_q;
      first_err_idx_d = first_err_idx_q;
      first_err_exp_d = first_err_exp_q;
      first_err_got_d = first_err_got_q;

      if (start) begin
         // A sample arriving with start is dropped, ref is reseeded.
         state_d         = ST_CHECK;
         ref_d           = seed_in;
         err_flag_d      = 1'b0;
         sample_count_d  = '0;
         err_count_d     = '0;
         first_err_idx_d = '0;
         first_err_exp_d = '0;
         first_err_got_d = '0;
      end else if (state_q == ST_CHECK) begin
         if (take) begin
            ref_d       = {ref_q[62:0], fb};
            chk_valid_d = 1'b1;
            chk_ok_d    = match;
            if (sample_count_q != CNT_MAX) begin
               sample_count_d = sample_count_q + CNT_ONE;
            end
            if (!match) begin
               err_flag_d = 1'b1;
               if (err_count_q != CNT_MAX) begin
                  err_count_d = err_count_q + CNT_ONE;
               end
               if (!err_flag_q) begin
                  first_err_idx_d = sample_count_q;
                  first_err_exp_d = exp_data;
                  first_err_got_d = in_data;
               end
            end
         end
         if (stop || (ERR_STOP && take && !match)) begin
            state_d = ST_DONE;
         end
      end

      busy_d = (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         ref_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         chk_valid_q     <= 1'b0;
         chk_ok_q        <= 1'b0;
         err_flag_q      <= 1'b0;
         sample_count_q  <= '0;
         err_count_q     <= '0;
         first_err_idx_q <= '0;
         first_err_exp_q <= '0;
         first_err_got_q <= '0;
      end else begin
         state_q         <= state_d;
         ref_q           <= ref_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         chk_valid_q     <= chk_valid_d;
         chk_ok_q        <= chk_ok_d;
         err_flag_q      <= err_flag_d;
         sample_count_q  <= sample_count_d;
         err_count_q     <= err_count_d;
         first_err_idx_q <= first_err_idx_d;
         first_err_exp_q <= first_err_exp_d;
         first_err_got_q <= first_err_got_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign chk_valid     = chk_valid_q;
   assign chk_ok        = chk_ok_q;
   assign err_flag      = err_flag_q;
   assign sample_count  = sample_count_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_err_idx_q;
   assign first_err_exp = first_err_exp_q;
   assign first_err_got = first_err_got_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: default, ERR_STOP=1 and
// CNT_W=4 instances share one stimulus stream.
module tb_lfsr_seq_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] seed_in = '0;
   logic        stop = 1'b0;
   logic        in_valid = 1'b0;
   logic [11:0] in_data = '0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   logic        o0_busy, o0_done, o0_cv, o0_ok, o0_ef;
   logic [31:0] o0_sc, o0_ec, o0_fi;
   logic [11:0] o0_fe, o0_fg;

   logic        o1_busy, o1_done, o1_cv, o1_ok, o1_ef;
   logic [31:0] o1_sc, o1_ec, o1_fi;
   logic [11:0] o1_fe, o1_fg;

   logic        o2_busy, o2_done, o2_cv, o2_ok, o2_ef;
   logic [3:0]  o2_sc, o2_ec, o2_fi;
   logic [11:0] o2_fe, o2_fg;

   lfsr_seq_checker #(.DATA_W(12), .CNT_W(32), .ERR_STOP(1'b0)) u0 (
      .clk(clk), .rst(rst), .start(start), .seed_in(seed_in),
      .stop(stop), .in_valid(in_valid), .in_data(in_data),
      .busy(o0_busy), .done(o0_done), .chk_valid(o0_cv),
      .chk_ok(o0_ok), .err_flag(o0_ef), .sample_count(o0_sc),
      .err_count(o0_ec), .first_err_idx(o0_fi),
      .first_err_exp(o0_fe), .first_err_got(o0_fg)
   );

   lfsr_seq_checker #(.DATA_W(12), .CNT_W(32), .ERR_STOP(1'b1)) u1 (
      .clk(clk), .rst(rst), .start(start), .seed_in(seed_in),
      .stop(stop), .in_valid(in_valid), .in_data(in_data),
      .busy(o1_busy), .done(o1_done), .chk_valid(o1_cv),
      .chk_ok(o1_ok), .err_flag(o1_ef), .sample_count(o1_sc),
      .err_count(o1_ec), .first_err_idx(o1_fi),
      .first_err_exp(o1_fe), .first_err_got(o1_fg)
   );

   lfsr_seq_checker #(.DATA_W(12), .CNT_W(4), .ERR_STOP(1'b0)) u2 (
      .clk(clk), .rst(rst), .start(start), .seed_in(seed_in),
      .stop(stop), .in_valid(in_valid), .in_data(in_data),
      .busy(o2_busy), .done(o2_done), .chk_valid(o2_cv),
      .chk_ok(o2_ok), .err_flag(o2_ef), .sample_count(o2_sc),
      .err_count(o2_ec), .first_err_idx(o2_fi),
      .first_err_exp(o2_fe), .first_err_got(o2_fg)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [63:0] seed);
      start   = 1'b1;
      seed_in = seed;
      tick();
      start   = 1'b0;
   endtask

   task automatic send(input logic [11:0] v);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
   endtask

   logic [11:0] vec;

   initial begin
      // Reset with a sample present: everything must be zero.
      in_valid = 1'b1;
      in_data  = 12'h123;
      tick();
      tick();
      in_valid = 1'b0;
      chk("rst_busy", 64'(o0_busy), 64'd0);
      chk("rst_done", 64'(o0_done), 64'd0);
      chk("rst_cv", 64'(o0_cv), 64'd0);
      chk("rst_ok", 64'(o0_ok), 64'd0);
      chk("rst_sc", 64'(o0_sc), 64'd0);
      chk("rst_fg", 64'(o0_fg), 64'd0);
      rst = 1'b0;

      // Seed 0: ones shift in from bit 0.
      do_start(64'd0);
      chk("s0_busy", 64'(o0_busy), 64'd1);
      chk("s0_sc0", 64'(o0_sc), 64'd0);
      for (int i = 0; i < 13; i++) begin
         vec = 12'((64'd1 << i) - 64'd1);
         send(vec);
         chk($sformatf("s0_cv%0d", i), 64'(o0_cv), 64'd1);
         chk($sformatf("s0_ok%0d", i), 64'(o0_ok), 64'd1);
      end
      tick();
      chk("s0_cv_off", 64'(o0_cv), 64'd0);
      chk("s0_sc", 64'(o0_sc), 64'd13);
      chk("s0_ec", 64'(o0_ec), 64'd0);
      chk("s0_ef", 64'(o0_ef), 64'd0);
      chk("s0_busy2", 64'(o0_busy), 64'd1);

      // Single error at index 2; reference keeps advancing.
      do_start(64'd0);
      send(12'h000);
      chk("se_ok0", 64'(o0_ok), 64'd1);
      send(12'h001);
      chk("se_ok1", 64'(o0_ok), 64'd1);
      send(12'h002);
      chk("se_cv2", 64'(o0_cv), 64'd1);
      chk("se_ok2", 64'(o0_ok), 64'd0);
      send(12'h007);
      chk("se_ok3", 64'(o0_ok), 64'd1);
      chk("se_ec", 64'(o0_ec), 64'd1);
      chk("se_ef", 64'(o0_ef), 64'd1);
      chk("se_fi", 64'(o0_fi), 64'd2);
      chk("se_fe", 64'(o0_fe), 64'h003);
      chk("se_fg", 64'(o0_fg), 64'h002);

      // Gaps in valid, then stop with a final sample.
      do_start(64'd0);
      send(12'h000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("gap_cv%0d", i), 64'(o0_cv), 64'd0);
      end
      send(12'h001);
      chk("gap_ok1", 64'(o0_ok), 64'd1);
      stop = 1'b1;
      send(12'h003);
      stop = 1'b0;
      chk("stp_cv", 64'(o0_cv), 64'd1);
      chk("stp_ok", 64'(o0_ok), 64'd1);
      chk("stp_sc", 64'(o0_sc), 64'd3);
      chk("stp_done", 64'(o0_done), 64'd1);
      chk("stp_busy", 64'(o0_busy), 64'd0);
      send(12'h007);
      chk("dn_cv", 64'(o0_cv), 64'd0);
      chk("dn_sc", 64'(o0_sc), 64'd3);
      chk("dn_done", 64'(o0_done), 64'd1);

      // ERR_STOP instance halts on first mismatch.
      do_start(64'd0);
      send(12'h000);
      chk("es_ok0", 64'(o1_ok), 64'd1);
      send(12'h005);
      chk("es_ok1", 64'(o1_ok), 64'd0);
      chk("es_done", 64'(o1_done), 64'd1);
      chk("es_busy", 64'(o1_busy), 64'd0);
      send(12'h003);
      chk("es_cv", 64'(o1_cv), 64'd0);
      chk("es_sc", 64'(o1_sc), 64'd2);
      chk("es_ec", 64'(o1_ec), 64'd1);
      chk("es_u0_busy", 64'(o0_busy), 64'd1);

      // Saturation on the CNT_W=4 instance.
      do_start(64'd0);
      for (int i = 0; i < 20; i++) send(12'hABC);
      chk("sat_sc", 64'(o2_sc), 64'd15);
      chk("sat_ec", 64'(o2_ec), 64'd15);
      chk("sat_fi", 64'(o2_fi), 64'd0);
      chk("sat_fe", 64'(o2_fe), 64'h000);
      chk("sat_fg", 64'(o2_fg), 64'hABC);
      chk("sat_u0_sc", 64'(o0_sc), 64'd20);
      chk("sat_u0_ec", 64'(o0_ec), 64'd20);

      // Restart mid-run with a valid sample: sample dropped.
      start    = 1'b1;
      seed_in  = 64'd0;
      in_valid = 1'b1;
      in_data  = 12'h000;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("rs_cv", 64'(o0_cv), 64'd0);
      chk("rs_sc", 64'(o0_sc), 64'd0);
      chk("rs_ec", 64'(o0_ec), 64'd0);
      chk("rs_ef", 64'(o0_ef), 64'd0);
      chk("rs_fg", 64'(o0_fg), 64'd0);
      send(12'h000);
      chk("rs_ok0", 64'(o0_ok), 64'd1);
      send(12'h001);
      chk("rs_ok1", 64'(o0_ok), 64'd1);
      chk("rs_sc2", 64'(o0_sc), 64'd2);

      // Mid-run reset, then a sample in IDLE is ignored.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy", 64'(o0_busy), 64'd0);
      chk("mr_done", 64'(o0_done), 64'd0);
      chk("mr_ok", 64'(o0_ok), 64'd0);
      chk("mr_sc", 64'(o0_sc), 64'd0);
      send(12'h000);
      chk("idl_cv", 64'(o0_cv), 64'd0);
      chk("idl_sc", 64'(o0_sc), 64'd0);
      chk("idl_busy", 64'(o0_busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
